// File: rtl/dcache_mem_responder_pkg.sv
// Shared data-cache definitions for the memory-side line responder:
// line geometry, data-memory map and the responder state encoding.
package dcache_mem_responder_pkg;

    localparam int          DMEM_WORD_BITS      = 32;
    localparam int          DMEM_LINE_WIDTH     = 128;
    localparam int          DMEM_WORDS_PER_LINE = DMEM_LINE_WIDTH / DMEM_WORD_BITS;
    localparam logic [31:0] DMEM_BASE_ADDR      = 32'h8000_0000;
    localparam int          DMEM_DEPTH_WORDS    = 4096;
    localparam int          DMEM_LATENCY        = 4;

    typedef enum logic [2:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_BEAT,
        DMEM_RESP,
        DMEM_HOLD
    } type_dmem_resp_states_e;

    // Counter width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int dmem_clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/dcache_mem_responder_dmem_word_sram.sv
// Single-port 1RW synchronous word SRAM, 32 bits wide, registered read,
// contents not reset so it maps onto block RAM.
module dmem_word_sram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data cache: serves line fills and write-backs
// from a word SRAM, one word per cycle after a programmable latency.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    LINE_WIDTH      = DMEM_LINE_WIDTH,
    parameter int                    MEM_DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(DMEM_BASE_ADDR),
    parameter int                    LATENCY         = DMEM_LATENCY
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
    output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
    output logic                  mem2dcache_ack_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int WORDS  = LINE_WIDTH / 32;
    localparam int IDX_W  = $clog2(MEM_DEPTH_WORDS);
    localparam int BEAT_W = dmem_clog2_min1(WORDS);
    localparam int CNT_W  = dmem_clog2_min1(LATENCY);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS * 4);

    type_dmem_resp_states_e state_reg, state_next;

    logic                  wr_reg;
    logic                  oor_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [LINE_WIDTH-1:0] wdata_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [BEAT_W-1:0]     beat_reg;
    logic                  pend_valid_reg;
    logic [BEAT_W-1:0]     pend_idx_reg;

    logic [ADDR_WIDTH-1:0] req_line;
    logic [ADDR_WIDTH-1:0] req_off;
    logic                  req_oor;
    logic                  capture;
    logic                  beat_last;
    logic [31:0]           wword [WORDS];
    logic [31:0]           pend_word;

    logic                  sram_en;
    logic                  sram_we;
    logic [IDX_W-1:0]      sram_addr;
    logic [31:0]           sram_rdata;

    // Wrap-around subtraction flags addresses below the base as well as above the top.
    assign req_line  = dcache2mem_addr_i & LINE_MASK;
    assign req_off   = req_line - BASE_ADDR;
    assign req_oor   = {1'b0, req_off} >= MEM_BYTES;
    assign capture   = (state_reg == DMEM_IDLE) && dcache2mem_req_i;
    assign beat_last = (beat_reg == BEAT_W'(WORDS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= DMEM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DMEM_IDLE: begin
                if (dcache2mem_req_i) begin
                    state_next = (LATENCY == 0) ? DMEM_BEAT : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = DMEM_BEAT;
                end
            end
            DMEM_BEAT: begin
                if (beat_last) begin
                    state_next = DMEM_RESP;
                end
            end
            DMEM_RESP: state_next = DMEM_HOLD;
            DMEM_HOLD: state_next = DMEM_IDLE;
            default:   state_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_reg         <= 1'b0;
            oor_reg        <= 1'b0;
            idx_reg        <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            beat_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pend_idx_reg   <= '0;
        end else begin
            if (capture) begin
                wr_reg    <= dcache2mem_wr_i;
                oor_reg   <= req_oor;
                idx_reg   <= req_off[IDX_W+1:2];
                wdata_reg <= dcache2mem_data_i;
                cnt_reg   <= CNT_W'(LATENCY - 1);
                beat_reg  <= '0;
            end
            if ((state_reg == DMEM_WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (state_reg == DMEM_BEAT) begin
                beat_reg <= beat_reg + 1'b1;
            end
            // A fill word issued this beat arrives from the SRAM next cycle.
            pend_valid_reg <= (state_reg == DMEM_BEAT) && !wr_reg;
            pend_idx_reg   <= beat_reg;
        end
    end

    // Reset is honoured on the SRAM port so an aborted write-back stops immediately.
    assign sram_en   = (state_reg == DMEM_BEAT) && !rst_i;
    assign sram_we   = sram_en && wr_reg && !oor_reg;
    assign sram_addr = idx_reg + IDX_W'(beat_reg);
    assign pend_word = oor_reg ? 32'h0 : sram_rdata;

    dmem_word_sram #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_sram (
        .clk   (clk_i),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (wword[beat_reg]),
        .rdata (sram_rdata)
    );

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            logic        word_hit;

            assign wword[gi] = wdata_reg[gi*32 +: 32];
            assign word_hit  = pend_valid_reg && (pend_idx_reg == BEAT_W'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    word_reg <= '0;
                end else if (word_hit) begin
                    word_reg <= pend_word;
                end
            end

            // Bypass lets the last word be seen in the ack cycle it arrives in.
            assign mem2dcache_data_o[gi*32 +: 32] = word_hit ? pend_word : word_reg;
        end
    endgenerate

    assign mem2dcache_ack_o = (state_reg == DMEM_RESP);
    assign err_o            = (state_reg == DMEM_RESP) && oor_reg;
    assign busy_o           = (state_reg != DMEM_IDLE);

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: a default-latency instance and a
// zero-latency instance, expected acks queued at request time.
module tb_dcache_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req, wr, req_z, wr_z;
    logic [31:0]  addr, addr_z;
    logic [127:0] wdata, wdata_z;
    logic [127:0] rdata, rdata_z;
    logic         ack, busy, err, ack_z, busy_z, err_z;

    typedef struct {
        int           cyc;
        logic         err;
        logic [127:0] data;
        logic         chk;
    } exp_t;

    exp_t q[$];
    exp_t qz[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    localparam logic [127:0] LINE_4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] LINE_6 = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
    localparam logic [127:0] LINE_5 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    localparam logic [127:0] LINE_D = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    localparam logic [127:0] LINE_7 = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
    localparam logic [127:0] LINE_F = {4{32'hFFFF_FFFF}};

    dcache_mem_responder dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .dcache2mem_req_i  (req),
        .dcache2mem_wr_i   (wr),
        .dcache2mem_addr_i (addr),
        .dcache2mem_data_i (wdata),
        .mem2dcache_data_o (rdata),
        .mem2dcache_ack_o  (ack),
        .busy_o            (busy),
        .err_o             (err)
    );

    dcache_mem_responder #(.LATENCY(0)) dut_z (
        .clk_i             (clk),
        .rst_i             (rst),
        .dcache2mem_req_i  (req_z),
        .dcache2mem_wr_i   (wr_z),
        .dcache2mem_addr_i (addr_z),
        .dcache2mem_data_i (wdata_z),
        .mem2dcache_data_o (rdata_z),
        .mem2dcache_ack_o  (ack_z),
        .busy_o            (busy_z),
        .err_o             (err_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            if (q.size() == 0) begin
                check_val("unexpected_ack", 128'(ack), 128'(0));
            end else begin
                e = q.pop_front();
                check_val("ack_cycle", 128'(cyc), 128'(e.cyc));
                check_val("err", 128'(err), 128'(e.err));
                if (e.chk) check_val("fill_data", rdata, e.data);
                $display("txn lat4 ack cyc=%0d err=%0b data=%h", cyc, err, rdata);
            end
        end
        if (ack_z) begin
            if (qz.size() == 0) begin
                check_val("unexpected_ack_z", 128'(ack_z), 128'(0));
            end else begin
                e = qz.pop_front();
                check_val("ack_cycle_z", 128'(cyc), 128'(e.cyc));
                check_val("err_z", 128'(err_z), 128'(e.err));
                if (e.chk) check_val("fill_data_z", rdata_z, e.data);
                $display("txn lat0 ack cyc=%0d err=%0b data=%h", cyc, err_z, rdata_z);
            end
        end
    end

    task automatic wait_ack(input bit z, input bit chk_busy);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0 && chk_busy) check_val("busy_first", 128'(z ? busy_z : busy), 128'(1));
            if (z ? ack_z : ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_val("ack_timeout", 128'(got), 128'(1));
    endtask

    task automatic txn(input bit z, input bit w, input logic [31:0] a, input logic [127:0] d,
                       input bit e_err, input logic [127:0] e_data, input bit chk);
        exp_t e;
        @(negedge clk);
        check_val("busy_idle", 128'(z ? busy_z : busy), 128'(0));
        if (z) begin
            req_z = 1'b1; wr_z = w; addr_z = a; wdata_z = d;
            e = '{cyc + 5, e_err, e_data, chk};
            qz.push_back(e);
        end else begin
            req = 1'b1; wr = w; addr = a; wdata = d;
            e = '{cyc + 9, e_err, e_data, chk};
            q.push_back(e);
        end
        wait_ack(z, 1'b1);
        @(negedge clk);
        check_val("busy_hold", 128'(z ? busy_z : busy), 128'(1));
        if (z) req_z = 1'b0;
        else   req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   start;
        rst = 1'b1;
        req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        req_z = 1'b0; wr_z = 1'b0; addr_z = '0; wdata_z = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ack", 128'(ack), 128'(0));
        check_val("rst_err", 128'(err), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_data", rdata, 128'(0));
        check_val("rst_busy_z", 128'(busy_z), 128'(0));
        check_val("rst_data_z", rdata_z, 128'(0));
        rst = 1'b0;

        // Write-back then fill of the same line.
        txn(0, 1, 32'h8000_0010, LINE_4, 0, '0, 0);
        txn(0, 0, 32'h8000_0010, '0, 0, LINE_4, 1);
        txn(0, 1, 32'h8000_0000, LINE_A, 0, '0, 0);
        txn(0, 0, 32'h8000_0000, '0, 0, LINE_A, 1);

        // Out-of-range: below base and just past the top.
        txn(0, 1, 32'h8000_3FF0, LINE_6, 0, '0, 0);
        txn(0, 0, 32'h7FFF_FFF0, '0, 1, '0, 1);
        txn(0, 0, 32'h8000_4000, '0, 1, '0, 1);
        txn(0, 1, 32'h7FFF_FFF0, LINE_F, 1, '0, 0);
        txn(0, 1, 32'h8000_4000, LINE_F, 1, '0, 0);
        txn(0, 0, 32'h8000_0000, '0, 0, LINE_A, 1);
        txn(0, 0, 32'h8000_3FF0, '0, 0, LINE_6, 1);

        // req held through HOLD: second capture only in cycle ack+2.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 32'h8000_0000;
        e = '{cyc + 9, 1'b0, LINE_A, 1'b1};
        q.push_back(e);
        wait_ack(0, 1'b1);
        @(negedge clk);
        check_val("busy_hold2", 128'(busy), 128'(1));
        addr = 32'h8000_0010;
        e = '{cyc + 10, 1'b0, LINE_4, 1'b1};
        q.push_back(e);
        wait_ack(0, 1'b0);
        @(negedge clk);
        req = 1'b0;

        // Reset during beat 2 of a write-back.
        txn(0, 1, 32'h8000_0100, LINE_5, 0, '0, 0);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h8000_0100; wdata = LINE_D;
        start = cyc;
        while (cyc < start + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_ack", 128'(ack), 128'(0));
        rst = 1'b0;
        req = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_val("abort_no_ack", 128'(ack), 128'(0));
        end
        txn(0, 0, 32'h8000_0100, '0, 0, {LINE_5[127:64], LINE_D[63:0]}, 1);

        // Zero-latency build, low address bits ignored.
        txn(1, 1, 32'h8000_0020, LINE_7, 0, '0, 0);
        txn(1, 0, 32'h8000_002F, '0, 0, LINE_7, 1);

        repeat (4) @(negedge clk);
        check_val("queue_empty", 128'(q.size()), 128'(0));
        check_val("queue_empty_z", 128'(qz.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
